// File: rtl/aes_sbox_pkg.sv
// Shared constants, FSM state encoding and affine-transform helpers for the
// arithmetic AES S-box server.
package aes_sbox_pkg;

    localparam logic [8:0]  AES_POLY = 9'h11B;
    localparam logic [7:0]  AFF_C    = 8'h63;
    localparam logic [7:0]  INVAFF_C = 8'h05;
    localparam int unsigned EXP_OPS  = 13;

    typedef enum logic [1:0] {
        IDLE,
        EXP,
        DONE
    } state_t;

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ AFF_C;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ INVAFF_C;
    endfunction

endpackage

// File: rtl/aes_sbox_server_gf_mul8.sv
// Combinational GF(2^8) multiplier, shift-and-add with reduction by AES_POLY.
module gf_mul8
    import aes_sbox_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] acc;
    logic [7:0] t;

    always_comb begin
        acc = '0;
        t   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ t;
            // multiply t by the field generator, folding bit 8 back through the polynomial
            t = t[7] ? ((t << 1) ^ AES_POLY[7:0]) : (t << 1);
        end
        p = acc;
    end

endmodule

// File: rtl/aes_sbox_server.sv
// Byte-serial AES S-box / inverse S-box server: x^254 by square-and-multiply,
// then (inverse) affine. Optional one-entry result cache via `AES_SBOX_CACHE_EN.
module aes_sbox_server
    import aes_sbox_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       decrypt_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       ready_o,
    output logic [7:0] data_o
);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [7:0] x;
    logic [7:0] r;
    logic       mode;
    logic [7:0] mul_b;
    logic [7:0] prod;
    logic [7:0] operand;
    logic [7:0] result;
    logic       hit;
    logic       accept;

    // even op counts square, odd op counts multiply by the operand
    assign mul_b   = cnt[0] ? x : r;
    assign operand = decrypt_i ? inv_affine(data_i) : data_i;
    assign result  = mode ? r : affine(r);

    gf_mul8 u_mul (
        .a (r),
        .b (mul_b),
        .p (prod)
    );

`ifdef AES_SBOX_CACHE_EN
    logic       cache_valid;
    logic       cache_mode;
    logic [7:0] cache_in;
    logic [7:0] cache_out;
    logic [7:0] din;

    assign hit = (state == IDLE) && start_i && cache_valid
                 && (cache_mode == decrypt_i) && (cache_in == data_i);
`else
    assign hit = 1'b0;
`endif

    assign accept = (state == IDLE) && start_i && !hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXP;
            EXP:     if (cnt == 4'(EXP_OPS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered off the DONE cycle, so ready_o appears with busy_o
    // already low and a request held on start_i is taken the very next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            x       <= '0;
            r       <= '0;
            mode    <= 1'b0;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
            data_o  <= '0;
`ifdef AES_SBOX_CACHE_EN
            cache_valid <= 1'b0;
            cache_mode  <= 1'b0;
            cache_in    <= '0;
            cache_out   <= '0;
            din         <= '0;
`endif
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode   <= decrypt_i;
                        x      <= operand;
                        r      <= operand;
                        cnt    <= '0;
                        busy_o <= 1'b1;
`ifdef AES_SBOX_CACHE_EN
                        din    <= data_i;
`endif
                    end
`ifdef AES_SBOX_CACHE_EN
                    if (hit) begin
                        ready_o <= 1'b1;
                        data_o  <= cache_out;
                    end
`endif
                end
                EXP: begin
                    r   <= prod;
                    cnt <= cnt + 4'd1;
                end
                DONE: begin
                    data_o  <= result;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
`ifdef AES_SBOX_CACHE_EN
                    cache_valid <= 1'b1;
                    cache_mode  <= mode;
                    cache_in    <= din;
                    cache_out   <= result;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
